// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and constants for the RS232 transmit/receive pair.
package rs232_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

endpackage

// File: rtl/rs232_sync.sv
// rs232_sync: two-flop synchronizer for an asynchronous input, both flops reset high.
module rs232_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/rs232_receiver.sv
// rs232_receiver: oversampling 8N1 serial receiver with start validation, mid-bit sampling
// and framing-error detection.
module rs232_receiver
    import rs232_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);

    logic                 rx_s, rx_prev_q;
    rx_state_t            state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d, busy_q, busy_d;

    rs232_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (rx_in),
        .q_o   (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = (state_q == IDLE) ? '0 : tick_q + TW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: state_d = (rx_prev_q && !rx_s) ? START : IDLE;
            START: if (tick_q == TICK_HALF) begin
                tick_d    = '0;
                bit_idx_d = '0;
                state_d   = rx_s ? IDLE : DATA;
            end
            DATA: if (tick_q == TICK_LAST) begin
                tick_d             = '0;
                shift_d[bit_idx_q] = rx_s;
                bit_idx_d          = bit_idx_q + 3'd1;
                state_d            = (bit_idx_q == 3'(DATA_BITS - 1)) ? STOP : DATA;
            end
            STOP: if (tick_q == TICK_LAST) begin
                tick_d  = '0;
                state_d = IDLE;
                valid_d = rx_s;
                ferr_d  = !rx_s;
                data_d  = rx_s ? shift_q : data_q;
            end
            default: state_d = IDLE;
        endcase
        // busy stays up through the strobe cycle so a consumer sees the frame end cleanly
        busy_d = (state_d != IDLE) || valid_d || ferr_d;
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rs232_receiver.sv
// tb_rs232_receiver: directed checks of rs232_receiver at N=16 and N=4 with pulse/timing monitors.
module tb_rs232_receiver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx16, rx4;
    logic [7:0] d16_data, d4_data;
    logic       d16_valid, d16_ferr, d16_busy;
    logic       d4_valid, d4_ferr, d4_busy;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t0, tf, ta, tr;
    int both16   = 0;
    int vt[$], ft[$], brise[$], bfall[$], v4t[$], f4t[$];
    logic [7:0] vd[$], v4d[$];
    logic busy_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rs232_receiver #(.CLKS_PER_BIT(16)) u_dut16 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx16),
        .data_out   (d16_data),
        .data_valid (d16_valid),
        .frame_err  (d16_ferr),
        .busy       (d16_busy)
    );

    rs232_receiver #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_in      (rx4),
        .data_out   (d4_data),
        .data_valid (d4_valid),
        .frame_err  (d4_ferr),
        .busy       (d4_busy)
    );

    always @(negedge clk) begin
        if (d16_valid) begin
            vt.push_back(cyc);
            vd.push_back(d16_data);
        end
        if (d16_ferr) ft.push_back(cyc);
        if (d16_valid && d16_ferr) both16++;
        if (d16_busy && !busy_prev) brise.push_back(cyc);
        if (!d16_busy && busy_prev) bfall.push_back(cyc);
        busy_prev = d16_busy;
        if (d4_valid) begin
            v4t.push_back(cyc);
            v4d.push_back(d4_data);
        end
        if (d4_ferr) f4t.push_back(cyc);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit fast, input logic v);
        if (fast) rx4 = v;
        else      rx16 = v;
    endtask

    task automatic send(input bit fast, input logic [7:0] b, input logic stop);
        int n = fast ? 4 : 16;
        drive(fast, 1'b0);
        t0 = cyc + 1;
        tick(n);
        for (int i = 0; i < 8; i++) begin
            drive(fast, b[i]);
            tick(n);
        end
        drive(fast, stop);
        tick(n);
    endtask

    task automatic clear();
        vt.delete(); vd.delete(); ft.delete(); brise.delete(); bfall.delete();
        v4t.delete(); v4d.delete(); f4t.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        rx16  = 1'b1;
        rx4   = 1'b1;
        @(posedge clk);
        #1;
        tick(3);
        check("rst_data", d16_data, 8'h00);
        check("rst_valid", d16_valid, 1'b0);
        check("rst_ferr", d16_ferr, 1'b0);
        check("rst_busy", d16_busy, 1'b0);
        check("rst_data4", d4_data, 8'h00);
        check("rst_busy4", d4_busy, 1'b0);
        rst_n = 1'b1;
        tick(5);

        clear();
        send(1'b0, 8'hA5, 1'b1);
        tick(10);
        check("a5_nvalid", vt.size(), 1);
        check("a5_data", (vd.size() > 0) ? vd[0] : 8'hxx, 8'hA5);
        check("a5_time", (vt.size() > 0) ? vt[0] : -1, t0 + 154);
        check("a5_noferr", ft.size(), 0);
        check("a5_busy_rise", (brise.size() > 0) ? brise[0] : -1, t0 + 2);
        check("a5_busy_fall", (bfall.size() > 0) ? bfall[0] : -1, t0 + 155);
        check("a5_data_hold", d16_data, 8'hA5);

        clear();
        send(1'b0, 8'h3C, 1'b0);
        tf = t0;
        tick(40);
        check("fe_count", ft.size(), 1);
        check("fe_time", (ft.size() > 0) ? ft[0] : -1, tf + 154);
        check("fe_novalid", vt.size(), 0);
        check("fe_data_kept", d16_data, 8'hA5);
        check("fe_no_retrigger", brise.size(), 1);
        check("fe_busy_idle", d16_busy, 1'b0);
        rx16 = 1'b1;
        tick(5);

        clear();
        send(1'b0, 8'h00, 1'b1);
        ta = t0;
        send(1'b0, 8'hFF, 1'b1);
        tick(10);
        check("b2b_count", vt.size(), 2);
        check("b2b_first", (vd.size() > 0) ? vd[0] : 8'hxx, 8'h00);
        check("b2b_second", (vd.size() > 1) ? vd[1] : 8'hxx, 8'hFF);
        check("b2b_first_time", (vt.size() > 0) ? vt[0] : -1, ta + 154);
        check("b2b_spacing", (vt.size() > 1) ? vt[1] - vt[0] : -1, 160);
        check("b2b_noferr", ft.size(), 0);

        clear();
        rx16 = 1'b0;
        tr = cyc + 1;
        tick(3);
        rx16 = 1'b1;
        tick(40);
        check("fs_busy_rise", (brise.size() > 0) ? brise[0] : -1, tr + 2);
        check("fs_busy_fall", (bfall.size() > 0) ? bfall[0] : -1, tr + 10);
        check("fs_novalid", vt.size(), 0);
        check("fs_noferr", ft.size(), 0);
        check("fs_data_kept", d16_data, 8'hFF);

        clear();
        rx16 = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rx16 = i[0] ? 1'b1 : 1'b0;
            tick(16);
        end
        rx16 = 1'b1;
        tick(8);
        check("mr_busy_before", d16_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mr_busy", d16_busy, 1'b0);
        check("mr_data", d16_data, 8'h00);
        check("mr_valid", d16_valid, 1'b0);
        check("mr_ferr", d16_ferr, 1'b0);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        send(1'b0, 8'h5A, 1'b1);
        tick(10);
        check("mr_count", vt.size(), 1);
        check("mr_next_data", (vd.size() > 0) ? vd[0] : 8'hxx, 8'h5A);
        check("mr_next_time", (vt.size() > 0) ? vt[0] : -1, t0 + 154);
        check("mr_noferr", ft.size(), 0);

        clear();
        send(1'b1, 8'h81, 1'b1);
        tick(10);
        check("n4_count", v4t.size(), 1);
        check("n4_data", (v4d.size() > 0) ? v4d[0] : 8'hxx, 8'h81);
        check("n4_time", (v4t.size() > 0) ? v4t[0] : -1, t0 + 40);
        check("n4_noferr", f4t.size(), 0);
        check("no_overlap", both16, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rs232_receiver.md
# rs232_receiver

Serial-to-parallel receive stage for the RS232 link. It sits directly downstream of the transmitter on the serial line. It oversamples the asynchronous line, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit. It checks the stop bit and presents each byte with a one-cycle valid strobe, or flags a framing error.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; even, ≥ 4
- clk  input  1  system clock; all logic on posedge
- rst_n  input  1  reset, asynchronous and active-low
- rx_in  input  1  asynchronous serial line; idles high
- data_out  output  8  last correctly framed byte; bit 0 is the first data bit received
- data_valid  output  1  one-cycle pulse; data_out updated in the same cycle
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- busy  output  1  high from start detection until return to IDLE

## Operation
- rx_in passes through a 2-flop synchronizer; both flops reset to 1. rx_s is the synchronizer output, rx_prev is rx_s delayed one cycle.
- Reset values: data_out=0x00, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
- Counter: tick, width $clog2(CLKS_PER_BIT). Bit index: bit_idx, 3 bits.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rx_prev=1 && rx_s=0 (falling edge) → START, tick=0, busy=1.
    - A line held low never retriggers; a fresh high→low edge is required.
  - START: tick increments each cycle. When tick = CLKS_PER_BIT/2−1, sample rx_s.
    - 0 → DATA, tick=0, bit_idx=0.
    - 1 → false start: → IDLE, no outputs pulse.
  - DATA: when tick = CLKS_PER_BIT−1, sample rx_s into shift register bit bit_idx, tick=0.
    - After bit_idx=7 is sampled → STOP; otherwise bit_idx+1.
  - STOP: when tick = CLKS_PER_BIT−1, sample rx_s.
    - 1 → data_out←shift register, data_valid=1.
    - 0 → frame_err=1, data_out unchanged.
    - Either way → IDLE, busy=0.
- data_valid and frame_err are never high together. Each is high for exactly one cycle per frame.
- Samples are taken at mid-bit, so the stop sample falls half a bit before the nominal end of the stop bit. Back-to-back frames with a single stop bit are received without loss.
- Reset mid-frame: everything returns to reset values asynchronously and no pulse is produced. After release, the next high→low edge starts a new frame.

## Timing
- Let N = CLKS_PER_BIT. Let edge T0 be the first posedge at which rx_in is low after being high.
  - rx_s falls at T0+1; START is entered at T0+2.
  - Start bit sampled at T0+2+N/2.
  - Data bit k sampled at T0+2+N/2+(k+1)·N.
  - data_valid / frame_err high in the cycle following T0+2+N/2+9N. For N=16 that is the cycle after edge T0+154.
- busy is registered: high from T0+2 through the strobe cycle, low the cycle after.
- No backpressure. The consumer must capture data_out on data_valid; data_out holds until the next valid frame.

## Structure
- Package rs232_pkg:
  - state enum rx_state_t {IDLE, START, DATA, STOP}
  - localparam DATA_BITS=8
  - Shared with the transmitter.
- Sub-module rs232_sync: 2-flop synchronizer with reset value 1. It is reusable on any async input.
- Top holds the FSM, tick counter, bit_idx, shift register and output registers.

## Test plan
- N=16, send 0xA5 framed (start 0, bits 1,0,1,0,0,1,0,1, stop 1) → one data_valid with data_out=0xA5 in the cycle after T0+154; frame_err stays 0.
- Send 0x00 then 0xFF back-to-back, one stop bit each → two data_valid pulses, values 0x00 then 0xFF, exactly 10·N cycles apart.
- Drive rx_in low for 3 cycles, then high → busy pulses, FSM returns to IDLE at start sample, no data_valid, no frame_err.
- Send 0x3C with stop bit 0, previous data_out=0xA5 → frame_err one cycle, data_out still 0xA5. Hold line low 40 cycles → no retrigger. Next edge receives normally.
- Assert rst_n low during bit 4 of a frame → all outputs zero immediately, busy=0. Subsequent 0x5A frame received correctly.
- N=4, send 0x81 → data_valid with 0x81 in the cycle after T0+2+2+36.
